// File: rtl/incr_pkg.sv
// ============================================================================
// Module   : incr_pkg
// Purpose  : Shared state encoding and widths for the incrementing sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package incr_pkg;

  localparam int c_data_w = 4;
  localparam int c_beat_w = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : incr_pkg

`default_nettype wire

// File: rtl/Incrementor.sv
// ============================================================================
// Module   : Incrementor
// Purpose  : Combinational 4-bit +1 with carry out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module Incrementor (
  input  logic [3:0] A,
  output logic [3:0] sum,
  output logic       carryOut
);

  assign {carryOut, sum} = {1'b0, A} + 5'd1;

endmodule : Incrementor

`default_nettype wire

// File: rtl/incr_sequencer.sv
// ============================================================================
// Module   : incr_sequencer
// Purpose  : Walks a 4-bit value start..end on a valid/ready stream, using
//            the Incrementor for the next value and its carry as wrap detect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module incr_sequencer
  import incr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [4:0]       beat_cnt
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_end;
  logic             r_wrap;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [4:0]       r_beat_cnt;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  Incrementor u_inc (
    .A        (r_cnt),
    .sum      (w_sum),
    .carryOut (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_end      <= '0;
      r_wrap     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt      <= start_val;
            r_end      <= end_val;
            r_wrap     <= wrap_en;
            r_ovf      <= 1'b0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_beat_cnt <= r_beat_cnt + 5'd1;
            // End match takes priority so end_val=15 with wrap off is not an overflow.
            if (r_cnt == r_end) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_carry && !r_wrap) begin
              r_ovf   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= w_sum;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_val   = r_cnt;
  assign out_valid = (r_state == EMIT);
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign beat_cnt  = r_beat_cnt;

endmodule : incr_sequencer

`default_nettype wire

// File: tb/tb_incr_sequencer.sv
// ============================================================================
// Module   : tb_incr_sequencer
// Purpose  : Scoreboard bench for incr_sequencer with directed sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_incr_sequencer;

  typedef struct {
    int beats;
    int ovf;
  } end_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] start_val;
  logic [3:0] end_val;
  logic       wrap_en;
  logic [3:0] out_val;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [4:0] beat_cnt;

  int   exp_beats[$];
  end_t exp_end[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  bit   prev_acc = 0;

  incr_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .wrap_en   (wrap_en),
    .out_val   (out_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) chk("beat_unexpected", exp_beats.size(), 1);
        else chk("beat_val", int'(out_val), exp_beats.pop_front());
      end
      if (done) begin
        chk("done_after_last_beat", int'(prev_acc), 1);
        chk("beats_drained_at_done", exp_beats.size(), 0);
        if (exp_end.size() == 0) begin
          chk("done_unexpected", exp_end.size(), 1);
        end else begin
          end_t e;
          e = exp_end.pop_front();
          chk("beat_cnt_at_done", int'(beat_cnt), e.beats);
          chk("ovf_at_done", int'(ovf), e.ovf);
        end
        n_done++;
      end
      prev_acc = out_valid && out_ready;
    end
  end

  task automatic start_seq(input int sv, input int ev, input bit wr);
    @(posedge clk); #1;
    start     = 1'b1;
    start_val = 4'(sv);
    end_val   = 4'(ev);
    wrap_en   = wr;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_latency_valid", int'(out_valid), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_ovf_cleared", int'(ovf), 0);
  endtask

  task automatic wait_done();
    int n0;
    n0 = n_done;
    for (int i = 0; i < 64 && n_done == n0; i++) @(posedge clk);
    if (n_done == n0) chk("done_timeout", n_done, n0 + 1);
    @(posedge clk); #1;
    chk("idle_after_done", int'(busy), 0);
    chk("valid_low_idle", int'(out_valid), 0);
  endtask

  task automatic push_beats(input int lo, input int n);
    for (int i = 0; i < n; i++) exp_beats.push_back((lo + i) % 16);
  endtask

  task automatic push_end(input int beats, input int o);
    end_t e;
    e.beats = beats;
    e.ovf   = o;
    exp_end.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_val = '0; end_val = '0;
    wrap_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_beat_cnt", int'(beat_cnt), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 3..7: beats 3,4,5,6,7
    push_beats(3, 5); push_end(5, 0);
    start_seq(3, 7, 1'b0);
    wait_done();

    // 14..1 with wrap: beats 14,15,0,1
    push_beats(14, 4); push_end(4, 0);
    start_seq(14, 1, 1'b1);
    wait_done();

    // 14..1 without wrap: beats 14,15 then overflow stop
    push_beats(14, 2); push_end(2, 1);
    start_seq(14, 1, 1'b0);
    wait_done();
    chk("ovf_sticky_idle", int'(ovf), 1);
    chk("beat_cnt_hold_idle", int'(beat_cnt), 2);

    // single beat held under backpressure
    out_ready = 1'b0;
    push_beats(10, 1); push_end(1, 0);
    start_seq(10, 10, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_val", int'(out_val), 10);
    end
    out_ready = 1'b1;
    wait_done();

    // 0..5 with a start pulse during the second beat that must be ignored
    push_beats(0, 6); push_end(6, 0);
    start_seq(0, 5, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; start_val = 4'd9; end_val = 4'd9; wrap_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // reset mid-run after beats 2,3 have been accepted
    push_beats(2, 2);
    start_seq(2, 12, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_val", int'(out_val), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_beat_cnt", int'(beat_cnt), 0);
    chk("midrst_sb_drained", exp_beats.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // normal run after reset: beats 6,7,8
    push_beats(6, 3); push_end(3, 0);
    start_seq(6, 8, 1'b0);
    wait_done();
    chk("final_beats_drained", exp_beats.size(), 0);
    chk("final_ends_drained", exp_end.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_incr_sequencer

`default_nettype wire

// File: doc/incr_sequencer.md
# incr_sequencer

Registered sequence generator that sits directly upstream of the combinational `Incrementor` and drives its `A` input. It walks a 4-bit value from a start value to an end value, one step per accepted beat, using `Incrementor.sum` as next value and `Incrementor.carryOut` as wrap detect. Each value is emitted on a valid/ready stream for downstream consumers.

## Interface
- `WIDTH`, 4, data width; fixed to match `Incrementor`, and other values are unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sequence; ignored unless IDLE.
- `start_val`  in  4  first value emitted; sampled when `start` is accepted.
- `end_val`  in  4  last value emitted, inclusive; sampled when `start` is accepted.
- `wrap_en`  in  1  1 allows passing 15→0; sampled when `start` is accepted.
- `out_val`  out  4  current value.
- `out_valid`  out  1  `out_val` is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a sequence ends.
- `ovf`  out  1  sticky flag: the sequence stopped on carry with `wrap_en`=0; cleared by the next accepted `start`.
- `beat_cnt`  out  5  beats accepted in the current or last sequence (0–16).

## Operation
- States: IDLE, EMIT, DONE.
- IDLE: when `start`=1, load `cnt`←`start_val`, `end_r`←`end_val`, `wrap_r`←`wrap_en`, `ovf`←0, `beat_cnt`←0, then go to EMIT.
- EMIT:
  - `out_valid`=1 and `out_val`=`cnt`. The Incrementor input is `A`=`cnt`.
  - On `out_ready`=1, increment `beat_cnt`, then:
    - if `cnt`==`end_r`: go to DONE.
    - else if `carryOut`=1 and `wrap_r`=0: set `ovf`←1 and go to DONE.
    - else: `cnt`←`sum` and stay in EMIT.
  - On `out_ready`=0, hold all state.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `cnt`, `beat_cnt` and `ovf` hold their values.
- Boundary conditions:
  - `start_val`==`end_val` → exactly one beat.
  - `wrap_en`=1 with `end_val`<`start_val` → the sequence wraps through 0.
  - `start` while busy → ignored, with no side effects.
- Reset, asynchronous at any time including mid-sequence: state→IDLE, `cnt`=0, `out_val`=0, `out_valid`=0, `busy`=0, `done`=0, `ovf`=0, `beat_cnt`=0. A partially emitted sequence is abandoned.

## Timing
- Start latency: `start` sampled at edge k → `out_valid`=1 during cycle k+1.
- Throughput: one beat per cycle while `out_ready`=1.
- A sequence of N beats with `out_ready` held high occupies N EMIT cycles plus 1 DONE cycle. The next `start` is accepted no earlier than the cycle after DONE.
- AXI-style valid rule:
  - Once `out_valid` rises, `out_valid` and `out_val` stay stable until the cycle in which `out_ready`=1.
  - `out_valid` must not depend combinationally on `out_ready`.
- All outputs are registered except `out_val`/`out_valid`, which are decoded directly from `cnt` and the state register. There is no combinational path from any input to any output.

## Structure
- State encoding constants (IDLE=2'd0, EMIT=2'd1, DONE=2'd2) live in the shared package/header `incr_pkg`, so the bench can reference them.
- One sub-module: the existing `Incrementor` (ports `A`, `sum`, `carryOut`), instantiated unchanged. The sequencer contains no adder of its own.
- Expected size is roughly 150 lines of RTL.

## Test plan
- Reset release, then `start`=1, `start_val`=3, `end_val`=7, `out_ready`=1 → beats 3,4,5,6,7 on consecutive cycles; `done` pulses the cycle after beat 7; `beat_cnt`=5; `ovf`=0.
- `start_val`=14, `end_val`=1, `wrap_en`=1 → beats 14,15,0,1; `beat_cnt`=4; `ovf`=0.
- `start_val`=14, `end_val`=1, `wrap_en`=0 → beats 14,15; then `done`; `ovf`=1; `beat_cnt`=2. `ovf` clears on the next `start`.
- `start_val`=`end_val`=10, with `out_ready` low for 3 cycles → `out_val`=10 held stable with `out_valid`=1 until `out_ready`=1; one beat; `done` next cycle.
- Assert `start` again during the second beat of a 0→5 run → ignored; the sequence completes unchanged. Assert `rst_n`=0 mid-run → all outputs 0 immediately; a later `start` runs normally from its `start_val`.
